// File: rtl/msrv32_fetch_sequencer_if.sv
// msrv32_fetch_sequencer_if: fetch-sequencer signal bundle; master = control/decoder/PC-mux side, slave = sequencer
interface msrv32_fetch_sequencer_if;
  logic        ahb_ready_in;
  logic [31:0] pc_mux_in;
  logic        misaligned_in;
  logic        illegal_instr_in;
  logic        ecall_in;
  logic        ebreak_in;
  logic        mret_in;
  logic        ext_irq_in;
  logic        irq_en_in;
  logic [1:0]  pc_src_out;
  logic [31:0] pc_out;
  logic        flush_out;
  logic        trap_taken_out;
  logic        mret_taken_out;
  logic [3:0]  cause_out;
  logic        cause_int_out;
  logic [31:0] epc_out;
  modport master (
    output ahb_ready_in, pc_mux_in, misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
           mret_in, ext_irq_in, irq_en_in,
    input  pc_src_out, pc_out, flush_out, trap_taken_out, mret_taken_out, cause_out,
           cause_int_out, epc_out
  );
  modport slave (
    input  ahb_ready_in, pc_mux_in, misaligned_in, illegal_instr_in, ecall_in, ebreak_in,
           mret_in, ext_irq_in, irq_en_in,
    output pc_src_out, pc_out, flush_out, trap_taken_out, mret_taken_out, cause_out,
           cause_int_out, epc_out
  );
endinterface

// File: rtl/msrv32_fetch_sequencer.sv
// msrv32_fetch_sequencer: owns the PC and sequences boot/run/trap/mret; ports clk_in, rst_in (sync, high), bus (slave: ready, pc mux, trap sources in; pc_src, pc, flush, pulses, cause/epc out)
module msrv32_fetch_sequencer #(
  parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2
) (
  input logic                    clk_in,
  input logic                    rst_in,
  msrv32_fetch_sequencer_if.slave bus
);
  localparam int CW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BOOT_CYCLES - 1);
  // encoding doubles as the pc_src value so the Moore decode is the state itself
  typedef enum logic [1:0] {BOOT = 2'b00, RETURN = 2'b01, TRAP = 2'b10, RUN = 2'b11} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [31:0] pc, epc;
  logic [3:0] cause;
  logic cause_int, trap_taken, mret_taken;
  logic exc, trap_hit, run_rdy, go_trap, go_ret, pc_load, in_xfer;
  always_comb begin
    state_d  = state;
    exc      = bus.misaligned_in | bus.illegal_instr_in | bus.ebreak_in | bus.ecall_in;
    trap_hit = exc | (bus.ext_irq_in & bus.irq_en_in);
    in_xfer  = state == TRAP || state == RETURN;
    run_rdy  = state == RUN && bus.ahb_ready_in;
    go_trap  = run_rdy && trap_hit;
    go_ret   = run_rdy && !trap_hit && bus.mret_in;
    pc_load  = bus.ahb_ready_in && (in_xfer || (state == RUN && !trap_hit && !bus.mret_in));
    state_d  = go_trap ? TRAP :
               go_ret ? RETURN :
               ((state == BOOT && cnt == CNT_LAST) || (in_xfer && bus.ahb_ready_in)) ? RUN : state;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= BOOT;
      cnt        <= '0;
      pc         <= BOOT_ADDR;
      epc        <= '0;
      cause      <= '0;
      cause_int  <= 1'b0;
      trap_taken <= 1'b0;
      mret_taken <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= state == BOOT ? cnt + 1'b1 : cnt;
      pc         <= pc_load ? bus.pc_mux_in : pc;
      trap_taken <= go_trap;
      mret_taken <= go_ret;
      if (go_trap) begin
        cause     <= bus.misaligned_in ? 4'd0 : bus.illegal_instr_in ? 4'd2 : bus.ebreak_in ? 4'd3 : 4'd11;
        cause_int <= !exc;
        // interrupts resume at the instruction that would have run next
        epc       <= exc ? pc : bus.pc_mux_in;
      end
    end
  end
  assign bus.pc_src_out     = state;
  assign bus.pc_out         = pc;
  assign bus.flush_out      = in_xfer;
  assign bus.trap_taken_out = trap_taken;
  assign bus.mret_taken_out = mret_taken;
  assign bus.cause_out      = cause;
  assign bus.cause_int_out  = cause_int;
  assign bus.epc_out        = epc;
endmodule

// File: tb/tb_msrv32_fetch_sequencer.sv
// tb_msrv32_fetch_sequencer: directed spec scenarios plus random stimulus checked against a behavioural model
module tb_msrv32_fetch_sequencer;
  localparam int BOOT_CYCLES = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errs = 0;
  int checks = 0;
  msrv32_fetch_sequencer_if bus();
  msrv32_fetch_sequencer #(.BOOT_ADDR(32'h0), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  byte m_mode;
  int m_boot_left;
  logic [31:0] m_pc, m_epc;
  logic [3:0] m_cause;
  logic m_int, m_trap_p, m_mret_p;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = "B"; m_boot_left = BOOT_CYCLES; m_pc = 0; m_epc = 0;
    m_cause = 0; m_int = 0; m_trap_p = 0; m_mret_p = 0;
  endtask
  task automatic take_trap(input logic [3:0] c, input logic i, input logic [31:0] e);
    m_mode = "T"; m_trap_p = 1; m_cause = c; m_int = i; m_epc = e;
  endtask
  // f = {misaligned, illegal, ecall, ebreak, mret, ext_irq, irq_en}
  task automatic model_step(input logic r, input logic rdy, input logic [31:0] mux, input logic [6:0] f);
    if (r) begin
      model_reset();
      return;
    end
    m_trap_p = 0; m_mret_p = 0;
    if (m_mode == "B") begin
      m_boot_left--;
      if (m_boot_left == 0) m_mode = "R";
    end else if (m_mode == "R") begin
      if (rdy) begin
        if (f[6]) take_trap(0, 0, m_pc);
        else if (f[5]) take_trap(2, 0, m_pc);
        else if (f[3]) take_trap(3, 0, m_pc);
        else if (f[4]) take_trap(11, 0, m_pc);
        else if (f[1] && f[0]) take_trap(11, 1, mux);
        else if (f[2]) begin m_mode = "M"; m_mret_p = 1; end
        else m_pc = mux;
      end
    end else if (rdy) begin
      m_pc = mux; m_mode = "R";
    end
  endtask
  function automatic logic [1:0] exp_src(input byte mode);
    return mode == "B" ? 2'b00 : mode == "M" ? 2'b01 : mode == "T" ? 2'b10 : 2'b11;
  endfunction
  task automatic cyc(input logic r, input logic rdy, input logic [31:0] mux, input logic [6:0] f);
    rst = r; bus.ahb_ready_in = rdy; bus.pc_mux_in = mux;
    {bus.misaligned_in, bus.illegal_instr_in, bus.ecall_in, bus.ebreak_in,
     bus.mret_in, bus.ext_irq_in, bus.irq_en_in} = f;
    @(negedge clk);
    chk("pc_src", 32'(bus.pc_src_out), 32'(exp_src(m_mode)));
    chk("pc", bus.pc_out, m_pc);
    chk("flush", 32'(bus.flush_out), 32'(m_mode == "T" || m_mode == "M"));
    chk("trap_taken", 32'(bus.trap_taken_out), 32'(m_trap_p));
    chk("mret_taken", 32'(bus.mret_taken_out), 32'(m_mret_p));
    chk("cause", 32'(bus.cause_out), 32'(m_cause));
    chk("cause_int", 32'(bus.cause_int_out), 32'(m_int));
    chk("epc", bus.epc_out, m_epc);
    model_step(r, rdy, mux, f);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [6:0] f;
    bus.ahb_ready_in = 0; bus.pc_mux_in = 0;
    {bus.misaligned_in, bus.illegal_instr_in, bus.ecall_in, bus.ebreak_in,
     bus.mret_in, bus.ext_irq_in, bus.irq_en_in} = '0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    repeat (3) cyc(1, 1, 32'h0, 7'b0);
    repeat (3) cyc(0, 0, 32'h0, 7'b0);
    cyc(0, 1, 32'h100, 7'b0);
    cyc(0, 1, 32'h104, 7'b0);
    cyc(0, 0, 32'h108, 7'b0);
    cyc(0, 1, 32'h108, 7'b0);
    cyc(0, 1, 32'h200, 7'b0);
    cyc(0, 1, 32'h204, 7'b0010011);
    cyc(0, 1, 32'h300, 7'b0);
    cyc(0, 1, 32'h304, 7'b0);
    cyc(0, 1, 32'h304, 7'b0000100);
    repeat (3) cyc(0, 0, 32'h200, 7'b0);
    cyc(0, 1, 32'h200, 7'b0);
    cyc(0, 1, 32'h204, 7'b1100000);
    cyc(0, 0, 32'h300, 7'b0);
    cyc(0, 1, 32'h300, 7'b0);
    cyc(0, 1, 32'h304, 7'b0001000);
    cyc(1, 0, 32'h300, 7'b0);
    cyc(0, 0, 32'h300, 7'b0);
    cyc(0, 1, 32'h300, 7'b0);
    cyc(0, 1, 32'h400, 7'b0000011);
    cyc(0, 1, 32'h500, 7'b0);
    cyc(0, 1, 32'h504, 7'b0);
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 6; b++) f[b + 1] = $urandom_range(0, 9) == 0;
      f[0] = $urandom_range(0, 1) == 1;
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom(), f);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
